// File: rtl/ram_sp_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Purpose  : Shared types and constants for the two-requester single-port RAM
//            arbiter: default bus widths, FSM state encoding and requester ids.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    // Requester ids double as bit positions in the req/gnt vectors.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/ram_sp_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_arbiter_if
// Purpose  : Bundles requester A/B handshakes, the shared RAM port and the
//            busy flag of ram_sp_arbiter.
// Ports    : a_* / b_*  requester request, grant and read-return signals
//            ram_*      single-port RAM command and read data
//            busy       clear in progress
// Modports : slave  - the arbiter
//            master - the environment (requesters and RAM)
// Revision : 1.0 - initial release
// ============================================================================
interface ram_sp_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt;
    logic              a_rvalid;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_gnt;
    logic              b_rvalid;
    logic [DATA_W-1:0] b_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    logic              busy;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_dout,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_we, ram_addr, ram_din,
        output busy
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_dout,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_we, ram_addr, ram_din,
        input  busy
    );

endinterface
`default_nettype wire

// File: rtl/ram_sp_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin arbiter. Grants are combinational; the
//            priority pointer flips to the other requester after each grant.
// Ports    : clk, rst  clock and synchronous active-high reset
//            en        grants are forced to zero while low
//            req[1:0]  request vector (bit REQ_A, bit REQ_B)
//            gnt[1:0]  one-hot grant, or zero
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import ram_arb_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       en,
    input  wire logic [1:0] req,
    output logic      [1:0] gnt
);

    // Id of the requester that wins when both request.
    logic r_pref;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (r_pref == REQ_A) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pref <= REQ_A;
        end else if (gnt[REQ_A]) begin
            r_pref <= REQ_B;
        end else if (gnt[REQ_B]) begin
            r_pref <= REQ_A;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_sp_arbiter
// Purpose  : Shares one single-port RAM (registered read address, write-first)
//            between requesters A and B. One access per cycle, round-robin
//            priority, read data returned one cycle after the grant.
//            Build option RAM_CLEAR_EN: after reset every word is written with
//            INIT_VAL (one word per cycle) and requesters stall meanwhile.
// Ports    : clk   system clock
//            rst   synchronous active-high reset
//            bus   ram_sp_arbiter_if.slave (requester A/B, RAM port, busy)
// Revision : 1.0 - initial release
// ============================================================================
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int              ADDR_W   = ADDR_W_DEF,
    parameter int              DATA_W   = DATA_W_DEF,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
)(
    input  wire logic          clk,
    input  wire logic          rst,
    ram_sp_arbiter_if.slave    bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_arb_en;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_clr_last;
    logic              r_a_rvalid;
    logic              r_b_rvalid;

`ifdef RAM_CLEAR_EN
    localparam arb_state_t ST_RESET = ST_INIT;

    logic [ADDR_W-1:0] r_clr_cnt;

    // Walks 0..DEPTH-1 while clearing; wraps back to 0 on the last write.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    assign w_clr_addr = r_clr_cnt;
    assign w_clr_last = (r_clr_cnt == ADDR_W'(DEPTH - 1));
    assign bus.busy   = (r_state == ST_INIT);
`else
    localparam arb_state_t ST_RESET = ST_RUN;

    assign w_clr_addr = '0;
    assign w_clr_last = 1'b1;
    assign bus.busy   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_req    = {bus.b_req, bus.a_req};
    assign w_arb_en = (r_state == ST_RUN) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk (clk),
        .rst (rst),
        .en  (w_arb_en),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign bus.a_gnt = w_gnt[REQ_A];
    assign bus.b_gnt = w_gnt[REQ_B];

    // ------------------------------------------------------------------
    // RAM port mux: clear writes take the port in INIT, otherwise the
    // granted requester drives it; idle port is all zeros.
    // ------------------------------------------------------------------
    always_comb begin
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_din  = '0;
        if (!rst) begin
            if (r_state == ST_INIT) begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = w_clr_addr;
                bus.ram_din  = INIT_VAL;
            end else if (w_gnt[REQ_A]) begin
                bus.ram_we   = bus.a_we;
                bus.ram_addr = bus.a_addr;
                bus.ram_din  = bus.a_wdata;
            end else if (w_gnt[REQ_B]) begin
                bus.ram_we   = bus.b_we;
                bus.ram_addr = bus.b_addr;
                bus.ram_din  = bus.b_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: the RAM registers the granted address at the end of the
    // grant cycle, so its output is the read data in the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_gnt[REQ_A] & ~bus.a_we;
            r_b_rvalid <= w_gnt[REQ_B] & ~bus.b_we;
        end
    end

    // A reset arriving the cycle after a read grant drops that rvalid at once.
    assign bus.a_rvalid = r_a_rvalid & ~rst;
    assign bus.b_rvalid = r_b_rvalid & ~rst;
    assign bus.a_rdata  = bus.ram_dout;
    assign bus.b_rdata  = bus.ram_dout;

endmodule
`default_nettype wire

// File: tb/tb_ram_sp_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sp_arbiter
// Purpose  : Self-checking bench for ram_sp_arbiter: directed scenarios plus
//            randomized requester traffic against a transaction-level model
//            (expected memory image, preferred-requester flag, pending reads).
//            Honours RAM_CLEAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sp_arbiter;

    localparam logic [7:0] INIT_V = 8'hA5;
`ifdef RAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_sp_arbiter_if #(.ADDR_W(6), .DATA_W(8)) bus ();

    ram_sp_arbiter #(.ADDR_W(6), .DATA_W(8), .INIT_VAL(INIT_V)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 5);
    endfunction

    // ---------------- RAM: registered address, write-first ----------------
    logic [7:0] mem [64];
    logic [5:0] ram_areg = '0;
    bit         ram_loaded = 1'b0;

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= pat(i);
            ram_loaded <= 1'b1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        ram_areg <= bus.ram_addr;
    end
    assign bus.ram_dout = mem[ram_areg];

    // ---------------- checking ----------------
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] ref_mem [64];
    bit         ref_loaded = 1'b0;
    bit         pref_b = 1'b0;      // 1: B wins a tie
    int         init_cnt = 0;       // words cleared since reset released
    bit         pa = 1'b0, pb = 1'b0;
    logic [7:0] da = '0, db = '0;
    bit         ega = 1'b0, egb = 1'b0;
    bit         ga, gb, in_init;

    always @(negedge clk) begin
        if (!ref_loaded) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
            ref_loaded = 1'b1;
        end
        ga = 1'b0;
        gb = 1'b0;
        if (rst) begin
            chk("rst_a_gnt",    bus.a_gnt,    0);
            chk("rst_b_gnt",    bus.b_gnt,    0);
            chk("rst_a_rvalid", bus.a_rvalid, 0);
            chk("rst_b_rvalid", bus.b_rvalid, 0);
            chk("rst_ram_we",   bus.ram_we,   0);
            chk("rst_ram_addr", bus.ram_addr, 0);
            chk("rst_ram_din",  bus.ram_din,  0);
            pref_b   = 1'b0;
            init_cnt = 0;
            pa = 1'b0;
            pb = 1'b0;
        end else begin
            in_init = CLR && (init_cnt < 64);
            if (!in_init) begin
                if (bus.a_req && bus.b_req) begin
                    ga = !pref_b;
                    gb = pref_b;
                end else begin
                    ga = bus.a_req;
                    gb = bus.b_req;
                end
            end
            chk("busy",     bus.busy,     in_init);
            chk("a_gnt",    bus.a_gnt,    ga);
            chk("b_gnt",    bus.b_gnt,    gb);
            chk("a_rvalid", bus.a_rvalid, pa);
            chk("b_rvalid", bus.b_rvalid, pb);
            if (pa) chk("a_rdata", bus.a_rdata, da);
            if (pb) chk("b_rdata", bus.b_rdata, db);
            if (in_init) begin
                chk("clr_we",   bus.ram_we,   1);
                chk("clr_addr", bus.ram_addr, init_cnt);
                chk("clr_din",  bus.ram_din,  INIT_V);
                ref_mem[init_cnt] = INIT_V;
                init_cnt++;
            end else if (ga || gb) begin
                chk("ram_we",   bus.ram_we,   ga ? bus.a_we   : bus.b_we);
                chk("ram_addr", bus.ram_addr, ga ? bus.a_addr : bus.b_addr);
                chk("ram_din",  bus.ram_din,  ga ? bus.a_wdata : bus.b_wdata);
                if (ga && bus.a_we) ref_mem[bus.a_addr] = bus.a_wdata;
                if (gb && bus.b_we) ref_mem[bus.b_addr] = bus.b_wdata;
            end else begin
                chk("idle_we",   bus.ram_we,   0);
                chk("idle_addr", bus.ram_addr, 0);
                chk("idle_din",  bus.ram_din,  0);
            end
            pa = ga && !bus.a_we;
            pb = gb && !bus.b_we;
            da = ref_mem[bus.a_addr];
            db = ref_mem[bus.b_addr];
            if (ga) pref_b = 1'b1;
            else if (gb) pref_b = 1'b0;
        end
        ega = ga;
        egb = gb;
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input bit req, input bit we, input logic [5:0] addr, input logic [7:0] wd);
        bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input logic [5:0] addr, input logic [7:0] wd);
        bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    endtask

    // New random request unless one is still waiting for its grant.
    task automatic rand_req();
        if (!(bus.a_req && !ega) || $urandom_range(0, 15) == 0)
            set_a($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                  6'($urandom_range(0, 7)), 8'($urandom));
        if (!(bus.b_req && !egb) || $urandom_range(0, 15) == 0)
            set_b($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
                  6'($urandom_range(0, 7)), 8'($urandom));
    endtask

    int         n_wait;
    bit         found;
    logic [7:0] exp_v;

    initial begin
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        rst = 1'b1;
        repeat (3) cyc();

        // Release reset with A reading the top word.
        rst = 1'b0;
        set_a(1, 0, 6'h3F, 8'h00);
        n_wait = 0;
        found  = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (bus.a_gnt) found = 1'b1;
            else n_wait++;
        end
        chk("first_gnt_cycle", found ? n_wait : 999, CLR ? 64 : 0);
        cyc();
        set_a(0, 0, '0, '0);
        exp_v = CLR ? INIT_V : pat(63);
        @(negedge clk);
        chk("first_read_valid", bus.a_rvalid, 1);
        chk("first_read_data",  bus.a_rdata,  exp_v);
        cyc();

        // Write then read the same word in consecutive cycles.
        set_a(1, 1, 6'h10, 8'h5C);
        cyc();
        set_a(1, 0, 6'h10, 8'h00);
        cyc();
        set_a(0, 0, '0, '0);
        @(negedge clk);
        chk("wr_rd_valid", bus.a_rvalid, 1);
        chk("wr_rd_data",  bus.a_rdata,  8'h5C);
        cyc();

        // Seed words 1 and 2, then both read continuously.
        set_a(1, 1, 6'h01, 8'h11);
        cyc();
        set_a(0, 0, '0, '0);
        set_b(1, 1, 6'h02, 8'h22);
        cyc();
        set_a(1, 0, 6'h01, 8'h00);
        set_b(1, 0, 6'h02, 8'h00);
        repeat (8) cyc();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        cyc();

        // B alone for 5 cycles, then both: A must win.
        set_b(1, 0, 6'h02, 8'h00);
        repeat (5) cyc();
        set_a(1, 0, 6'h01, 8'h00);
        @(negedge clk);
        chk("a_first_after_b", bus.a_gnt, 1);
        cyc();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        cyc();

        // A raises and drops a write while B holds the grant.
        set_a(1, 0, 6'h05, 8'h00);
        cyc();
        set_a(1, 1, 6'h30, 8'hEE);
        set_b(1, 0, 6'h06, 8'h00);
        @(negedge clk);
        chk("cancel_b_gnt", bus.b_gnt, 1);
        cyc();
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        cyc();
        set_a(1, 0, 6'h30, 8'h00);
        cyc();
        set_a(0, 0, '0, '0);
        exp_v = CLR ? INIT_V : pat(48);
        @(negedge clk);
        chk("cancel_no_write", bus.a_rdata, exp_v);
        cyc();

        // Reset the cycle after a read grant.
        set_a(1, 0, 6'h07, 8'h00);
        cyc();
        set_a(0, 0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_drop_rvalid", bus.a_rvalid, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", bus.a_rvalid, 0);
        chk("post_rst_busy",   bus.busy,     CLR);
        cyc();

        // Random traffic with one reset pulse in the middle.
        for (int c = 0; c < 2500; c++) begin
            rst = (c == 1200);
            rand_req();
            cyc();
        end
        rst = 1'b0;
        set_a(0, 0, '0, '0);
        set_b(0, 0, '0, '0);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
